// File: rtl/regfile_commit_sequencer_pkg.sv
// Shared types and constants for the regfile commit sequencer.
// Contents:
//   ROB_IDX_W, REG_IDX_W, DATA_W  field widths of a commit
//   rob_to_regfile                one commit: valid, rob_idx, regfile_idx, value
//   seq_state_e                   RUN / DRAIN sequencer states
package regfile_commit_sequencer_pkg;

  localparam int ROB_IDX_W = 5;
  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;

  typedef struct packed {
    logic                 valid;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [REG_IDX_W-1:0] regfile_idx;
    logic [DATA_W-1:0]    value;
  } rob_to_regfile;

  typedef enum logic {
    SEQ_RUN   = 1'b0,
    SEQ_DRAIN = 1'b1
  } seq_state_e;

endpackage

// File: rtl/regfile_commit_sequencer_commit_buffer.sv
// In-order circular buffer of pending regfile commits.
// Accepts up to two writes per cycle (slot 0 lands before slot 1), pops the
// head every cycle it holds an entry, and searches occupied entries for the
// youngest value written to a given architectural register.
// Ports:
//   i_clk, i_rst                    clock, synchronous active-high reset
//   i_wr_0 / i_data_0               older write enable and commit
//   i_wr_1 / i_data_1               younger write enable and commit
//   o_head                          head entry, valid whenever count != 0
//   o_count                         registered occupancy
//   i_lookup_idx_1/2                registers to search for
//   o_hit_1/2, o_val_1/2            match flag and youngest matching value
module regfile_commit_sequencer_commit_buffer
  import regfile_commit_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_wr_0,
  input  rob_to_regfile              i_data_0,
  input  logic                       i_wr_1,
  input  rob_to_regfile              i_data_1,
  output rob_to_regfile              o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  input  logic [REG_IDX_W-1:0]       i_lookup_idx_1,
  input  logic [REG_IDX_W-1:0]       i_lookup_idx_2,
  output logic                       o_hit_1,
  output logic [DATA_W-1:0]          o_val_1,
  output logic                       o_hit_2,
  output logic [DATA_W-1:0]          o_val_2
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  rob_to_regfile    r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic             w_deq;
  logic [1:0]       w_n_enq;
  logic [PTR_W-1:0] w_tail_1;
  logic [PTR_W-1:0] w_slot;

  assign w_deq   = (r_count != '0);
  assign w_n_enq = {1'b0, i_wr_0} + {1'b0, i_wr_1};
  // Slot 1 goes right behind slot 0 only when slot 0 is actually written.
  assign w_tail_1 = r_tail + PTR_W'(i_wr_0);

  // Storage carries no reset: occupancy alone decides which entries are live.
  always_ff @(posedge i_clk) begin
    if (i_wr_0) r_mem[r_tail] <= i_data_0;
    if (i_wr_1) r_mem[w_tail_1] <= i_data_1;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_tail  <= r_tail + PTR_W'(w_n_enq);
      r_head  <= r_head + PTR_W'(w_deq);
      r_count <= r_count + CNT_W'(w_n_enq) - CNT_W'(w_deq);
    end
  end

  always_comb begin
    o_head       = r_mem[r_head];
    o_head.valid = w_deq;
  end

  assign o_count = r_count;

  // Walk from head towards tail; later matches overwrite earlier ones so the
  // youngest entry wins. Register 0 never matches.
  always_comb begin
    o_hit_1 = 1'b0;
    o_val_1 = '0;
    o_hit_2 = 1'b0;
    o_val_2 = '0;
    w_slot  = r_head;
    for (int k = 0; k < DEPTH; k++) begin
      w_slot = r_head + PTR_W'(k);
      if (CNT_W'(k) < r_count) begin
        if ((i_lookup_idx_1 != '0) && (r_mem[w_slot].regfile_idx == i_lookup_idx_1)) begin
          o_hit_1 = 1'b1;
          o_val_1 = r_mem[w_slot].value;
        end
        if ((i_lookup_idx_2 != '0) && (r_mem[w_slot].regfile_idx == i_lookup_idx_2)) begin
          o_hit_2 = 1'b1;
          o_val_2 = r_mem[w_slot].value;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_commit_sequencer.sv
// Regfile commit sequencer: buffers up to two ROB retirements per cycle and
// drains them one per cycle onto the regfile commit bus, with a lookup bypass
// for buffered values and an ordered drain on flush.
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_commit_0 / i_commit_1       older / younger retiring slot
//   o_commit_ready                ROB may present commits this cycle
//   o_rob_regfile_bus             single commit to the regfile
//   i_flush_req                   request drain of all buffered commits
//   o_drain_done                  one-cycle pulse when the drain completes
//   i_lookup_idx_1/2              IQ source registers
//   o_lookup_hit_1/2, _val_1/2    bypass hit and youngest buffered value
//   o_occupancy                   buffered entry count
module regfile_commit_sequencer
  import regfile_commit_sequencer_pkg::rob_to_regfile,
         regfile_commit_sequencer_pkg::seq_state_e,
         regfile_commit_sequencer_pkg::SEQ_RUN,
         regfile_commit_sequencer_pkg::SEQ_DRAIN,
         regfile_commit_sequencer_pkg::REG_IDX_W,
         regfile_commit_sequencer_pkg::DATA_W;
#(
  parameter int DEPTH     = 4,
  parameter int ROB_IDX_W = 5
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  rob_to_regfile              i_commit_0,
  input  rob_to_regfile              i_commit_1,
  output logic                       o_commit_ready,
  output rob_to_regfile              o_rob_regfile_bus,
  input  logic                       i_flush_req,
  output logic                       o_drain_done,
  input  logic [REG_IDX_W-1:0]       i_lookup_idx_1,
  input  logic [REG_IDX_W-1:0]       i_lookup_idx_2,
  output logic                       o_lookup_hit_1,
  output logic [DATA_W-1:0]          o_lookup_val_1,
  output logic                       o_lookup_hit_2,
  output logic [DATA_W-1:0]          o_lookup_val_2,
  output logic [$clog2(DEPTH+1)-1:0] o_occupancy
);

  localparam int CNT_W = $clog2(DEPTH+1);

  seq_state_e       r_state;
  seq_state_e       w_state_next;
  logic             w_drain_done;
  logic             w_ready;
  logic             w_wr_0;
  logic             w_wr_1;
  logic [CNT_W-1:0] w_count;
  rob_to_regfile    w_head;
  logic             w_hit_1;
  logic             w_hit_2;
  logic [DATA_W-1:0] w_val_1;
  logic [DATA_W-1:0] w_val_2;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= SEQ_RUN;
    else       r_state <= w_state_next;
  end

  // Flush is only sampled in RUN; DRAIN waits for the buffer to empty and
  // signals completion in the cycle it observes an empty buffer.
  always_comb begin
    w_state_next = r_state;
    w_drain_done = 1'b0;
    unique case (r_state)
      SEQ_RUN: begin
        if (i_flush_req) w_state_next = SEQ_DRAIN;
      end
      SEQ_DRAIN: begin
        if (w_count == '0) begin
          w_drain_done = 1'b1;
          w_state_next = SEQ_RUN;
        end
      end
      default: w_state_next = SEQ_RUN;
    endcase
  end

  // Ready needs room for a full pair, and depends only on registered state
  // (plus reset) so the ROB never sees a loop through its own commit inputs.
  assign w_ready = !i_rst && (r_state == SEQ_RUN) && (w_count <= CNT_W'(DEPTH-2));

  // Writes to register 0 carry no architectural effect and are dropped.
  assign w_wr_0 = w_ready && i_commit_0.valid && (i_commit_0.regfile_idx != '0);
  assign w_wr_1 = w_ready && i_commit_1.valid && (i_commit_1.regfile_idx != '0);

  regfile_commit_sequencer_commit_buffer #(
    .DEPTH (DEPTH)
  ) u_buffer (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_wr_0         (w_wr_0),
    .i_data_0       (i_commit_0),
    .i_wr_1         (w_wr_1),
    .i_data_1       (i_commit_1),
    .o_head         (w_head),
    .o_count        (w_count),
    .i_lookup_idx_1 (i_lookup_idx_1),
    .i_lookup_idx_2 (i_lookup_idx_2),
    .o_hit_1        (w_hit_1),
    .o_val_1        (w_val_1),
    .o_hit_2        (w_hit_2),
    .o_val_2        (w_val_2)
  );

  // Outputs are held quiet while reset is asserted.
  always_comb begin
    o_rob_regfile_bus       = w_head;
    o_rob_regfile_bus.valid = w_head.valid && !i_rst;
  end

  assign o_commit_ready = w_ready;
  assign o_drain_done   = w_drain_done && !i_rst;
  assign o_occupancy    = w_count;
  assign o_lookup_hit_1 = w_hit_1 && !i_rst;
  assign o_lookup_val_1 = i_rst ? '0 : w_val_1;
  assign o_lookup_hit_2 = w_hit_2 && !i_rst;
  assign o_lookup_val_2 = i_rst ? '0 : w_val_2;

  a_count_bound : assert property (@(posedge i_clk) disable iff (i_rst)
    w_count <= CNT_W'(DEPTH));
  a_no_commit_unready : assert property (@(posedge i_clk) disable iff (i_rst)
    !o_commit_ready |-> !(i_commit_0.valid || i_commit_1.valid));
  a_drain_done_state : assert property (@(posedge i_clk) disable iff (i_rst)
    o_drain_done |-> (r_state == SEQ_DRAIN));
  a_rob_idx_width : assert property (@(posedge i_clk)
    $bits(i_commit_0.rob_idx) == ROB_IDX_W);

endmodule

// File: tb/tb_regfile_commit_sequencer.sv
// Directed bench for regfile_commit_sequencer (DEPTH=4).
// Inputs change 1 time unit after the rising edge; outputs are checked on
// the falling edge of the same cycle.
module tb_regfile_commit_sequencer;
  import regfile_commit_sequencer_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  rob_to_regfile c0, c1, bus;
  logic          ready, flush, drainDone;
  logic [4:0]    lk1, lk2;
  logic          hit1, hit2;
  logic [31:0]   val1, val2;
  logic [2:0]    occ;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_commit_sequencer #(.DEPTH(4), .ROB_IDX_W(5)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_commit_0        (c0),
    .i_commit_1        (c1),
    .o_commit_ready    (ready),
    .o_rob_regfile_bus (bus),
    .i_flush_req       (flush),
    .o_drain_done      (drainDone),
    .i_lookup_idx_1    (lk1),
    .i_lookup_idx_2    (lk2),
    .o_lookup_hit_1    (hit1),
    .o_lookup_val_1    (val1),
    .o_lookup_hit_2    (hit2),
    .o_lookup_val_2    (val2),
    .o_occupancy       (occ)
  );

  function automatic rob_to_regfile mk(input int rob, input int rd, input logic [31:0] v);
    rob_to_regfile e;
    e.valid       = 1'b1;
    e.rob_idx     = 5'(rob);
    e.regfile_idx = 5'(rd);
    e.value       = v;
    return e;
  endfunction

  task automatic idleInputs();
    c0 = '0;
    c1 = '0;
    flush = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; idleInputs(); lk1 = 5'd3; lk2 = 5'd0;
    repeat (2) nextCycle();
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", ready); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_bus_valid: got %b expected 0", bus.valid); end
    checks++; if (occ !== 3'd0) begin errors++; $display("[TB] FAIL reset_occ: got %0d expected 0", occ); end
    checks++; if (drainDone !== 1'b0) begin errors++; $display("[TB] FAIL reset_drain_done: got %b expected 0", drainDone); end
    checks++; if (hit1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_hit1: got %b expected 0", hit1); end
    nextCycle();
    rst = 1'b0; lk1 = 5'd0;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_ready: got %b expected 1", ready); end
    nextCycle();
  endtask

  task automatic test_single();
    c0 = mk(5, 3, 32'hDEADBEEF);
    @(negedge clk);
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL single_no_passthrough: got %b expected 0", bus.valid); end
    nextCycle(); idleInputs();
    @(negedge clk);
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("[TB] FAIL single_bus_valid: got %b expected 1", bus.valid); end
    checks++; if (bus.rob_idx !== 5'd5) begin errors++; $display("[TB] FAIL single_rob: got %0d expected 5", bus.rob_idx); end
    checks++; if (bus.regfile_idx !== 5'd3) begin errors++; $display("[TB] FAIL single_rd: got %0d expected 3", bus.regfile_idx); end
    checks++; if (bus.value !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL single_value: got %h expected deadbeef", bus.value); end
    checks++; if (occ !== 3'd1) begin errors++; $display("[TB] FAIL single_occ1: got %0d expected 1", occ); end
    nextCycle();
    @(negedge clk);
    checks++; if (occ !== 3'd0) begin errors++; $display("[TB] FAIL single_occ0: got %0d expected 0", occ); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL single_bus_idle: got %b expected 0", bus.valid); end
    nextCycle();
  endtask

  task automatic test_rd_zero();
    c0 = mk(8, 0, 32'h55);
    c1 = mk(9, 7, 32'h11);
    nextCycle(); idleInputs();
    @(negedge clk);
    checks++; if (occ !== 3'd1) begin errors++; $display("[TB] FAIL rd0_occ: got %0d expected 1", occ); end
    checks++; if (bus.rob_idx !== 5'd9 || bus.regfile_idx !== 5'd7 || bus.value !== 32'h11)
      begin errors++; $display("[TB] FAIL rd0_bus: got rob %0d rd %0d val %h expected rob 9 rd 7 val 11", bus.rob_idx, bus.regfile_idx, bus.value); end
    nextCycle();
    @(negedge clk);
    checks++; if (bus.valid !== 1'b0 || occ !== 3'd0) begin errors++; $display("[TB] FAIL rd0_empty: got valid %b occ %0d expected 0 0", bus.valid, occ); end
    nextCycle();
  endtask

  task automatic test_lookup();
    c0 = mk(10, 9, 32'h1);
    c1 = mk(11, 9, 32'h2);
    lk1 = 5'd9; lk2 = 5'd9;
    @(negedge clk);
    checks++; if (hit1 !== 1'b0) begin errors++; $display("[TB] FAIL lookup_same_cycle: got %b expected 0", hit1); end
    nextCycle(); idleInputs(); lk2 = 5'd0;
    @(negedge clk);
    checks++; if (hit1 !== 1'b1 || val1 !== 32'h2) begin errors++; $display("[TB] FAIL lookup_youngest: got hit %b val %h expected 1 2", hit1, val1); end
    checks++; if (hit2 !== 1'b0 || val2 !== 32'h0) begin errors++; $display("[TB] FAIL lookup_idx0: got hit %b val %h expected 0 0", hit2, val2); end
    nextCycle();
    @(negedge clk);
    checks++; if (hit1 !== 1'b1 || val1 !== 32'h2) begin errors++; $display("[TB] FAIL lookup_head_only: got hit %b val %h expected 1 2", hit1, val1); end
    nextCycle();
    @(negedge clk);
    checks++; if (hit1 !== 1'b0 || val1 !== 32'h0) begin errors++; $display("[TB] FAIL lookup_empty: got hit %b val %h expected 0 0", hit1, val1); end
    nextCycle();
    c0 = mk(12, 4, 32'hA);
    c1 = mk(13, 6, 32'hB);
    lk1 = 5'd4; lk2 = 5'd6;
    nextCycle(); idleInputs();
    @(negedge clk);
    checks++; if (hit1 !== 1'b1 || val1 !== 32'hA) begin errors++; $display("[TB] FAIL lookup_old_entry: got hit %b val %h expected 1 a", hit1, val1); end
    checks++; if (hit2 !== 1'b1 || val2 !== 32'hB) begin errors++; $display("[TB] FAIL lookup_new_entry: got hit %b val %h expected 1 b", hit2, val2); end
    nextCycle();
    @(negedge clk);
    checks++; if (hit1 !== 1'b0) begin errors++; $display("[TB] FAIL lookup_after_deq: got %b expected 0", hit1); end
    checks++; if (hit2 !== 1'b1 || val2 !== 32'hB) begin errors++; $display("[TB] FAIL lookup_remaining: got hit %b val %h expected 1 b", hit2, val2); end
    nextCycle();
    lk1 = 5'd0; lk2 = 5'd0;
    nextCycle();
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got[$];
    bit sawFull = 0;
    bit sawStall = 0;
    for (int cyc = 0; cyc < 40 && got.size() < 8; cyc++) begin
      if (sent < 8 && ready === 1'b1) begin
        c0 = mk(sent, sent + 1, 32'(100 + sent));
        c1 = mk(sent + 1, sent + 2, 32'(101 + sent));
        sent += 2;
      end else begin
        idleInputs();
      end
      @(negedge clk);
      checks++; if (ready !== (occ <= 3'd2)) begin errors++; $display("[TB] FAIL b2b_ready: got %b expected %b at occ %0d", ready, (occ <= 3'd2), occ); end
      if (occ == 3'd3) sawFull = 1;
      if (ready === 1'b0) sawStall = 1;
      if (bus.valid === 1'b1) got.push_back(int'(bus.rob_idx));
      nextCycle();
    end
    idleInputs();
    checks++; if (got.size() != 8) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      checks++; if (got[i] != i) begin errors++; $display("[TB] FAIL b2b_order[%0d]: got %0d expected %0d", i, got[i], i); end
    end
    checks++; if (!(sawFull && sawStall)) begin errors++; $display("[TB] FAIL b2b_backpressure: got full %0d stall %0d expected 1 1", sawFull, sawStall); end
  endtask

  task automatic test_flush();
    c0 = mk(20, 1, 32'h20);
    c1 = mk(21, 2, 32'h21);
    nextCycle();
    checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_ready_fill: got %b expected 1", ready); end
    c0 = mk(22, 3, 32'h22);
    c1 = mk(23, 4, 32'h23);
    @(negedge clk);
    checks++; if (bus.rob_idx !== 5'd20) begin errors++; $display("[TB] FAIL flush_bus20: got %0d expected 20", bus.rob_idx); end
    nextCycle(); idleInputs(); flush = 1'b1;
    @(negedge clk);
    checks++; if (occ !== 3'd3 || ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_start: got occ %0d ready %b expected 3 0", occ, ready); end
    checks++; if (bus.valid !== 1'b1 || bus.rob_idx !== 5'd21 || drainDone !== 1'b0)
      begin errors++; $display("[TB] FAIL flush_bus21: got valid %b rob %0d done %b expected 1 21 0", bus.valid, bus.rob_idx, drainDone); end
    nextCycle(); flush = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_ready_drain: got %b expected 0", ready); end
    checks++; if (bus.valid !== 1'b1 || bus.rob_idx !== 5'd22 || drainDone !== 1'b0)
      begin errors++; $display("[TB] FAIL flush_bus22: got valid %b rob %0d done %b expected 1 22 0", bus.valid, bus.rob_idx, drainDone); end
    nextCycle();
    @(negedge clk);
    checks++; if (bus.valid !== 1'b1 || bus.rob_idx !== 5'd23 || drainDone !== 1'b0 || ready !== 1'b0)
      begin errors++; $display("[TB] FAIL flush_bus23: got valid %b rob %0d done %b ready %b expected 1 23 0 0", bus.valid, bus.rob_idx, drainDone, ready); end
    nextCycle();
    @(negedge clk);
    checks++; if (drainDone !== 1'b1 || bus.valid !== 1'b0 || occ !== 3'd0 || ready !== 1'b0)
      begin errors++; $display("[TB] FAIL flush_done: got done %b valid %b occ %0d ready %b expected 1 0 0 0", drainDone, bus.valid, occ, ready); end
    nextCycle();
    @(negedge clk);
    checks++; if (drainDone !== 1'b0 || ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_resume: got done %b ready %b expected 0 1", drainDone, ready); end
    nextCycle();
  endtask

  task automatic test_flush_empty();
    flush = 1'b1;
    @(negedge clk);
    checks++; if (drainDone !== 1'b0 || ready !== 1'b1) begin errors++; $display("[TB] FAIL fempty_req: got done %b ready %b expected 0 1", drainDone, ready); end
    nextCycle(); flush = 1'b0;
    @(negedge clk);
    checks++; if (drainDone !== 1'b1 || ready !== 1'b0) begin errors++; $display("[TB] FAIL fempty_done: got done %b ready %b expected 1 0", drainDone, ready); end
    nextCycle();
    @(negedge clk);
    checks++; if (drainDone !== 1'b0 || ready !== 1'b1) begin errors++; $display("[TB] FAIL fempty_resume: got done %b ready %b expected 0 1", drainDone, ready); end
    nextCycle();
  endtask

  task automatic test_reset_mid();
    c0 = mk(30, 5, 32'h30);
    c1 = mk(31, 6, 32'h31);
    nextCycle(); idleInputs();
    lk1 = 5'd6; rst = 1'b1;
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_ready_in_rst: got %b expected 0", ready); end
    nextCycle();
    @(negedge clk);
    checks++; if (bus.valid !== 1'b0 || occ !== 3'd0) begin errors++; $display("[TB] FAIL rstmid_cleared: got valid %b occ %0d expected 0 0", bus.valid, occ); end
    checks++; if (ready !== 1'b0 || hit1 !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_quiet: got ready %b hit %b expected 0 0", ready, hit1); end
    nextCycle(); rst = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b1 || hit1 !== 1'b0 || occ !== 3'd0 || bus.valid !== 1'b0)
      begin errors++; $display("[TB] FAIL rstmid_after: got ready %b hit %b occ %0d valid %b expected 1 0 0 0", ready, hit1, occ, bus.valid); end
    nextCycle();
    lk1 = 5'd0;
  endtask

  initial begin
    rst = 1'b1;
    idleInputs();
    lk1 = '0;
    lk2 = '0;
    test_reset();
    test_single();
    test_rd_zero();
    test_lookup();
    test_back_to_back();
    test_flush();
    test_flush_empty();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
